adc_capture_framer: RTL and testbench

- Downstream stage of the ADC capture controller; one instance per ADC channel.
- Consumes one 32-bit gated sample stream, where each contiguous run of s_axis_tvalid high is one capture burst of two 16-bit samples per word.
- Buffers the stream in an internal FIFO and re-emits it as a back-pressurable AXI-Stream with m_axis_tlast on the final word of each burst, ready for a DMA engine.
- Counts frames and reports overflow, because upstream never stalls.

---
 rtl/adc_capture_framer.sv | 158 +++++++++++++++
 tb/tb_adc_capture_framer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_framer.sv
// Per-channel ADC burst framer: a one-word hold stage finds the end of each burst
// (tlast), then a FIFO with a registered FWFT output feeds a back-pressurable AXI-Stream.
module adc_capture_framer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              rf_clk,
  input  logic              rf_reset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  input  logic              clear_status,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [15:0]       frame_count,
  output logic [ADDR_W:0]   fill_level
);

  localparam int              DEPTH   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  // Handshake: a transfer happens on m_axis at a rising edge where m_axis_tvalid and
  // m_axis_tready are both high; tvalid never drops and tdata/tlast never change
  // while waiting for tready. The input side is always ready outside reset.

  logic              ready_q;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic [DATA_W:0]   mem [DEPTH];

  logic              push_vld;
  logic              push_last;
  logic              push_ok;
  logic              drop;
  logic              pop;
  logic              load_out;
  logic [ADDR_W:0]   mem_count;
  logic [ADDR_W:0]   fill;
  logic [15:0]       drop_base;
  logic [DATA_W:0]   rd_word;

  // Hold stage: the held word is pushed once the next cycle shows whether the
  // burst continues; a gap in tvalid marks the held word as the frame's last.
  always_comb begin
    push_vld     = hold_valid_q;
    push_last    = !s_axis_tvalid;
    hold_valid_d = s_axis_tvalid;
    hold_data_d  = hold_data_q;
    if (s_axis_tvalid) begin
      hold_data_d = s_axis_tdata;
    end
  end

  // Occupancy counts the output register too, so the acceptance test covers both.
  always_comb begin
    mem_count = wr_ptr_q - rd_ptr_q;
    fill      = mem_count + {{ADDR_W{1'b0}}, out_valid_q};
    push_ok   = push_vld && (fill < DEPTH_L);
    drop      = push_vld && !push_ok;
    pop       = out_valid_q && m_axis_tready;
    load_out  = (mem_count != '0) && (!out_valid_q || m_axis_tready);
    rd_word   = mem[rd_ptr_q[ADDR_W-1:0]];
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (load_out) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      out_valid_d = 1'b1;
      out_last_d  = rd_word[DATA_W];
      out_data_d  = rd_word[DATA_W-1:0];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // A drop in the same cycle as a clear wins: the clear happens first, then the drop counts.
  always_comb begin
    drop_base   = clear_status ? 16'h0000 : drop_cnt_q;
    drop_cnt_d  = drop_base;
    overflow_d  = clear_status ? 1'b0 : overflow_q;
    frame_cnt_d = frame_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_base != 16'hFFFF) begin
        drop_cnt_d = drop_base + 16'h0001;
      end
    end
    if (push_ok && push_last) begin
      frame_cnt_d = frame_cnt_q + 16'h0001;
    end
  end

  always_ff @(posedge rf_clk or negedge rf_reset) begin
    if (!rf_reset) begin
      ready_q      <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      frame_cnt_q  <= '0;
    end else begin
      ready_q      <= 1'b1;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  // Storage is not reset; pointer reset is what flushes it.
  always_ff @(posedge rf_clk) begin
    if (push_ok) begin
      mem[wr_ptr_q[ADDR_W-1:0]] <= {push_last, hold_data_q};
    end
  end

  assign s_axis_tready = ready_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tdata  = out_data_q;
  assign overflow      = overflow_q;
  assign drop_count    = drop_cnt_q;
  assign frame_count   = frame_cnt_q;
  assign fill_level    = fill;

endmodule

// File: tb/tb_adc_capture_framer.sv
// Bench for adc_capture_framer (16-deep FIFO): directed scenarios plus random bursts,
// checked against a queue-based model of frames, occupancy and status counters.
module tb_adc_capture_framer;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rf_reset;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              clear_status;
  logic              overflow;
  logic [15:0]       drop_count;
  logic [15:0]       frame_count;
  logic [ADDR_W:0]   fill_level;

  adc_capture_framer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .rf_clk        (clk),
    .rf_reset      (rf_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .clear_status  (clear_status),
    .overflow      (overflow),
    .drop_count    (drop_count),
    .frame_count   (frame_count),
    .fill_level    (fill_level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: exp_q holds accepted {last, data} words in delivery order.
  logic [DATA_W:0]   exp_q[$];
  int                m_fill;
  int                m_frames;
  int                m_drops;
  bit                m_ovf;
  bit                m_ready;
  bit                m_hold_v;
  logic [DATA_W-1:0] m_hold_d;
  int                pop_count;
  bit                prev_stall;
  logic [DATA_W-1:0] prev_data;
  logic              prev_last;

  // The model advances on the falling edge, predicting what the next rising edge does.
  always @(negedge clk) begin
    if (!rf_reset) begin
      exp_q.delete();
      m_fill     = 0;
      m_frames   = 0;
      m_drops    = 0;
      m_ovf      = 1'b0;
      m_ready    = 1'b0;
      m_hold_v   = 1'b0;
      m_hold_d   = '0;
      pop_count  = 0;
      prev_stall = 1'b0;
    end else begin
      bit              pop;
      bit              drop;
      int              accept;
      logic [DATA_W:0] front;
      check_eq("fill_level", 32'(fill_level), 32'(m_fill));
      check_eq("overflow", 32'(overflow), 32'(m_ovf));
      check_eq("drop_count", 32'(drop_count), 32'(m_drops));
      check_eq("frame_count", 32'(frame_count), 32'(m_frames & 16'hFFFF));
      check_eq("s_tready", 32'(s_axis_tready), 32'(m_ready));
      if (prev_stall) begin
        check_eq("stall_valid", 32'(m_axis_tvalid), 32'd1);
        check_eq("stall_data", m_axis_tdata, prev_data);
        check_eq("stall_last", 32'(m_axis_tlast), 32'(prev_last));
      end
      pop    = m_axis_tvalid && m_axis_tready;
      drop   = 1'b0;
      accept = 0;
      if (pop) begin
        pop_count++;
        if (exp_q.size() == 0) begin
          check_eq("pop_with_empty_model", 32'd1, 32'd0);
        end else begin
          front = exp_q.pop_front();
          check_eq("out_data", m_axis_tdata, front[DATA_W-1:0]);
          check_eq("out_last", 32'(m_axis_tlast), 32'(front[DATA_W]));
        end
      end
      // A held word leaves once the next cycle is known; a gap makes it the frame end.
      if (m_hold_v) begin
        if (m_fill < DEPTH) begin
          exp_q.push_back({!s_axis_tvalid, m_hold_d});
          accept = 1;
          if (!s_axis_tvalid) m_frames = (m_frames + 1) % 65536;
        end else begin
          drop = 1'b1;
        end
      end
      if (clear_status) begin
        m_ovf   = 1'b0;
        m_drops = 0;
      end
      if (drop) begin
        m_ovf = 1'b1;
        if (m_drops < 65535) m_drops++;
      end
      m_fill     = m_fill + accept - (pop ? 1 : 0);
      m_hold_v   = s_axis_tvalid;
      m_hold_d   = s_axis_tdata;
      m_ready    = 1'b1;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // driver tasks
  task automatic drive_cycle(input logic v, input logic [DATA_W-1:0] d, input logic rdy,
                             input logic clr);
    @(posedge clk);
    #1;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = rdy;
    clear_status  = clr;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rf_reset      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    clear_status  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rf_reset = 1'b1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_fill != 0) && n < budget) begin
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    idle(2, 1'b1);
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int pc0;
    int burst_left;
    rf_reset      = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    clear_status  = 1'b0;
    #1;
    check_eq("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check_eq("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("rst_m_tdata", m_axis_tdata, 32'd0);
    check_eq("rst_fill", 32'(fill_level), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rf_reset = 1'b1;

    // 1: four-word burst, latency and streaming
    drive_cycle(1'b1, 32'h1, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'h2, 1'b1, 1'b0);
    check_eq("t1_lat_e0", 32'(m_axis_tvalid), 32'd0);
    drive_cycle(1'b1, 32'h3, 1'b1, 1'b0);
    check_eq("t1_lat_e1", 32'(m_axis_tvalid), 32'd0);
    drive_cycle(1'b1, 32'h4, 1'b1, 1'b0);
    check_eq("t1_lat_e2_valid", 32'(m_axis_tvalid), 32'd1);
    check_eq("t1_lat_e2_data", m_axis_tdata, 32'h1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    check_eq("t1_next_data", m_axis_tdata, 32'h2);
    idle(6, 1'b1);
    check_eq("t1_frames", 32'(frame_count), 32'd1);
    check_eq("t1_pops", 32'(pop_count), 32'd4);

    // 2: single-word burst
    drive_cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
    idle(6, 1'b1);
    check_eq("t2_frames", 32'(frame_count), 32'd2);
    check_eq("t2_pops", 32'(pop_count), 32'd5);

    // 3: overflow on a 20-word burst into a 16-deep FIFO
    do_reset();
    for (int i = 1; i <= 20; i++) drive_cycle(1'b1, 32'(i), 1'b0, 1'b0);
    idle(4, 1'b0);
    check_eq("t3_fill", 32'(fill_level), 32'd16);
    check_eq("t3_ovf", 32'(overflow), 32'd1);
    check_eq("t3_drops", 32'(drop_count), 32'd4);
    check_eq("t3_frames", 32'(frame_count), 32'd0);
    pc0 = pop_count;
    drain(60);
    check_eq("t3_pops", 32'(pop_count - pc0), 32'd16);

    // 4: stalled output with alternating tready
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    idle(4, 1'b0);
    check_eq("t4_fill_q", 32'(fill_level), 32'd3);
    pc0 = pop_count;
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, (i % 2) == 0, 1'b0);
    idle(2, 1'b0);
    check_eq("t4_pops", 32'(pop_count - pc0), 32'd3);
    check_eq("t4_fill", 32'(fill_level), 32'd0);

    // 5: clear colliding with a drop
    do_reset();
    for (int i = 0; i < 22; i++) drive_cycle(1'b1, $urandom(), 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    check_eq("t5_pre_drops", 32'(drop_count), 32'd5);
    check_eq("t5_pre_ovf", 32'(overflow), 32'd1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("t5_ovf", 32'(overflow), 32'd1);
    check_eq("t5_drops", 32'(drop_count), 32'd1);
    idle(2, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    check_eq("t5_clr_ovf", 32'(overflow), 32'd0);
    check_eq("t5_clr_drops", 32'(drop_count), 32'd0);
    drain(60);

    // 6: asynchronous reset mid-burst
    for (int i = 1; i <= 3; i++) drive_cycle(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rf_reset      = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check_eq("t6_s_tready", 32'(s_axis_tready), 32'd0);
    check_eq("t6_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check_eq("t6_m_tlast", 32'(m_axis_tlast), 32'd0);
    check_eq("t6_m_tdata", m_axis_tdata, 32'd0);
    check_eq("t6_ovf", 32'(overflow), 32'd0);
    check_eq("t6_drops", 32'(drop_count), 32'd0);
    check_eq("t6_frames", 32'(frame_count), 32'd0);
    check_eq("t6_fill", 32'(fill_level), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rf_reset = 1'b1;
    drive_cycle(1'b1, 32'h611, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'h612, 1'b1, 1'b0);
    idle(8, 1'b1);
    check_eq("t6_pops", 32'(pop_count), 32'd2);
    check_eq("t6_frames_after", 32'(frame_count), 32'd1);

    // random bursts, gaps, back-pressure and clears
    burst_left = 0;
    for (int c = 0; c < 800; c++) begin
      logic rdy;
      logic clr;
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 60) == 0);
      if (burst_left > 0) begin
        drive_cycle(1'b1, $urandom(), rdy, clr);
        burst_left--;
      end else begin
        for (int g = 0; g < $urandom_range(0, 3); g++) drive_cycle(1'b0, '0, rdy, clr);
        burst_left = $urandom_range(1, 24);
      end
    end
    drain(200);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
